// File: rtl/int_controller_pkg.sv
// Shared definitions for the interrupt controller: state encodings, vector defaults, line count.
// Also holds the handler-vector helper so the address arithmetic lives in one place.
package int_controller_pkg;

    localparam int          N_IRQ_DEF     = 8;
    localparam logic [15:0] VEC_BASE_DEF  = 16'h0100;
    localparam int          VEC_SHIFT_DEF = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    function automatic logic [15:0] vec_addr(input logic [15:0] base,
                                             input int          shift,
                                             input logic [2:0]  id);
        return base + ({13'd0, id} << shift);
    endfunction

endpackage

// File: rtl/int_controller_prio_enc8.sv
// Fixed-priority encoder: index of the lowest set bit of an 8-bit vector, plus a valid flag.
// Purely combinational.
module prio_enc8 (
    input  logic [7:0] in_vec,
    output logic [2:0] idx,
    output logic       vld
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = 3'd0;
        vld = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (in_vec[i]) begin
                idx = 3'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_controller.sv
// 8-line interrupt controller: edge capture, enable mask, fixed priority, ack/eoi handshake.
// Request is registered (REQ one edge after pending appears); nesting enabled by INT_NEST_EN.
module int_controller
    import int_controller_pkg::*;
#(
    parameter int          N_IRQ     = N_IRQ_DEF,
    parameter logic [15:0] VEC_BASE  = VEC_BASE_DEF,
    parameter int          VEC_SHIFT = VEC_SHIFT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             ie_we,
    input  logic [N_IRQ-1:0] ie_wdata,
    output logic [N_IRQ-1:0] ie,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] in_service,
    output logic             int_req,
    output logic [15:0]      int_vector,
    input  logic             int_ack,
    input  logic             int_eoi
);

    logic [N_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic [N_IRQ-1:0] ie_q, ie_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] in_service_q, in_service_d;
    logic             int_req_q, int_req_d;
    logic [15:0]      int_vector_q, int_vector_d;
    logic [2:0]       id_q, id_d;
    state_t           state_q, state_d;

    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] eligible;
    logic [2:0]       elig_idx;
    logic             elig_vld;
    logic [2:0]       isr_idx;
    logic             isr_vld;

    assign rise     = irq_in & ~irq_prev_q;
    assign eligible = pending_q & ie_q;

    prio_enc8 u_enc_elig (
        .in_vec (eligible),
        .idx    (elig_idx),
        .vld    (elig_vld)
    );

    prio_enc8 u_enc_isr (
        .in_vec (in_service_q),
        .idx    (isr_idx),
        .vld    (isr_vld)
    );

    always_comb begin
        irq_prev_d   = irq_in;
        ie_d         = ie_we ? ie_wdata : ie_q;
        pending_d    = pending_q;
        in_service_d = in_service_q;
        int_req_d    = int_req_q;
        int_vector_d = int_vector_q;
        id_d         = id_q;
        state_d      = state_q;

        case (state_q)
            IDLE: begin
                if (elig_vld) begin
                    id_d         = elig_idx;
                    int_vector_d = vec_addr(VEC_BASE, VEC_SHIFT, elig_idx);
                    int_req_d    = 1'b1;
                    state_d      = REQ;
                end
            end
            REQ: begin
                // id is committed here; mask changes or new edges cannot retarget it.
                if (int_ack) begin
                    pending_d[id_q]    = 1'b0;
                    in_service_d[id_q] = 1'b1;
                    int_req_d          = 1'b0;
                    state_d            = SERVICE;
                end
            end
            SERVICE: begin
                if (int_eoi) begin
                    if (isr_vld) begin
                        in_service_d[isr_idx] = 1'b0;
                    end
                    if (in_service_d == '0) begin
                        state_d = IDLE;
                    end
                end
`ifdef INT_NEST_EN
                else if (elig_vld && (!isr_vld || (elig_idx < isr_idx))) begin
                    id_d         = elig_idx;
                    int_vector_d = vec_addr(VEC_BASE, VEC_SHIFT, elig_idx);
                    int_req_d    = 1'b1;
                    state_d      = REQ;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A fresh edge on the line being acknowledged must survive the clear.
        pending_d = pending_d | rise;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_prev_q   <= '0;
            ie_q         <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            int_req_q    <= 1'b0;
            int_vector_q <= VEC_BASE;
            id_q         <= 3'd0;
            state_q      <= IDLE;
        end else begin
            irq_prev_q   <= irq_prev_d;
            ie_q         <= ie_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            int_req_q    <= int_req_d;
            int_vector_q <= int_vector_d;
            id_q         <= id_d;
            state_q      <= state_d;
        end
    end

    assign ie         = ie_q;
    assign pending    = pending_q;
    assign in_service = in_service_q;
    assign int_req    = int_req_q;
    assign int_vector = int_vector_q;

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller: expected handler vectors are queued as stimulus is driven
// and popped when the controller raises int_req.
module tb_int_controller;

    logic        clk;
    logic        reset;
    logic [7:0]  irq_in;
    logic        ie_we;
    logic [7:0]  ie_wdata;
    logic [7:0]  ie;
    logic [7:0]  pending;
    logic [7:0]  in_service;
    logic        int_req;
    logic [15:0] int_vector;
    logic        int_ack;
    logic        int_eoi;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    int_controller dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .ie_we      (ie_we),
        .ie_wdata   (ie_wdata),
        .ie         (ie),
        .pending    (pending),
        .in_service (in_service),
        .int_req    (int_req),
        .int_vector (int_vector),
        .int_ack    (int_ack),
        .int_eoi    (int_eoi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_ie(input logic [7:0] v);
        ie_we    = 1'b1;
        ie_wdata = v;
        tick();
        ie_we    = 1'b0;
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Bounded wait for int_req, then compare the vector against the scoreboard head.
    task automatic wait_req(input string tag);
        logic [15:0] e;
        int n;
        n = 0;
        while (int_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (int_req !== 1'b1) begin
            check({tag, "_req_timeout"}, 16'(int_req), 16'd1);
        end else if (exp_q.size() == 0) begin
            check({tag, "_sb_underflow"}, 16'(exp_q.size()), 16'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_vec"}, int_vector, e);
        end
    endtask

    task automatic serve(input string tag, input logic [7:0] isr_exp);
        wait_req(tag);
        pulse_ack();
        check({tag, "_req_drop"}, 16'(int_req), 16'd0);
        check({tag, "_isr"}, 16'(in_service), 16'(isr_exp));
        pulse_eoi();
        check({tag, "_isr_clr"}, 16'(in_service), 16'd0);
    endtask

    initial begin
        reset    = 1'b0;
        irq_in   = 8'hFF;
        ie_we    = 1'b0;
        ie_wdata = 8'h00;
        int_ack  = 1'b0;
        int_eoi  = 1'b0;

        // Held in reset with all lines high.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ie", 16'(ie), 16'h00);
            check("rst_pend", 16'(pending), 16'h00);
            check("rst_req", 16'(int_req), 16'd0);
        end
        check("rst_vec", int_vector, 16'h0100);
        reset = 1'b1;
        tick();
        check("masked_pend", 16'(pending), 16'hFF);
        tick();
        tick();
        check("masked_req", 16'(int_req), 16'd0);

        irq_in = 8'h00;
        do_reset();
        write_ie(8'hFF);

        // Stray ack/eoi in IDLE do nothing.
        int_ack = 1'b1;
        int_eoi = 1'b1;
        tick();
        int_ack = 1'b0;
        int_eoi = 1'b0;
        check("stray_isr", 16'(in_service), 16'h00);
        check("stray_req", 16'(int_req), 16'd0);

        // Three lines at once: 0, 4, 7.
        irq_in = 8'h91;
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'h0108);
        exp_q.push_back(16'h010E);
        tick();
        irq_in = 8'h00;
        check("p91_pend", 16'(pending), 16'h91);
        check("p91_req_1clk", 16'(int_req), 16'd0);
        tick();
        check("p91_req_2clk", 16'(int_req), 16'd1);
        serve("l0", 8'h01);

        // Masking after commit does not retract line 4.
        wait_req("l4");
        write_ie(8'h00);
        check("l4_req_held", 16'(int_req), 16'd1);
        check("l4_vec_held", int_vector, 16'h0108);
        pulse_ack();
        check("l4_pend", 16'(pending), 16'h80);
        check("l4_isr", 16'(in_service), 16'h10);
        pulse_eoi();
        check("l4_isr_clr", 16'(in_service), 16'h00);
        write_ie(8'hFF);
        serve("l7", 8'h80);
        check("p91_pend_end", 16'(pending), 16'h00);

        // Line 6 in service, line 2 arrives.
        irq_in = 8'h40;
        exp_q.push_back(16'h010C);
        tick();
        irq_in = 8'h00;
        wait_req("l6");
        pulse_ack();
        check("l6_isr", 16'(in_service), 16'h40);
        irq_in = 8'h04;
        exp_q.push_back(16'h0104);
        tick();
        irq_in = 8'h00;
        check("l2_pend", 16'(pending), 16'h04);
`ifdef INT_NEST_EN
        wait_req("nest_l2");
        pulse_ack();
        check("nest_isr", 16'(in_service), 16'h44);
        pulse_eoi();
        check("nest_isr_eoi1", 16'(in_service), 16'h40);
        check("nest_req_quiet", 16'(int_req), 16'd0);
        pulse_eoi();
        check("nest_isr_eoi2", 16'(in_service), 16'h00);
`else
        tick();
        tick();
        check("no_preempt_req", 16'(int_req), 16'd0);
        pulse_eoi();
        check("l6_isr_clr", 16'(in_service), 16'h00);
        check("eoi_gap_req", 16'(int_req), 16'd0);
        tick();
        check("eoi_next_req", 16'(int_req), 16'd1);
        serve("l2_after", 8'h04);
`endif

        // New edge on line 3 coinciding with its ack; eoi in the same cycle is ignored.
        irq_in = 8'h08;
        exp_q.push_back(16'h0106);
        tick();
        irq_in = 8'h00;
        wait_req("l3");
        irq_in  = 8'h08;
        int_ack = 1'b1;
        int_eoi = 1'b1;
        exp_q.push_back(16'h0106);
        tick();
        irq_in  = 8'h00;
        int_ack = 1'b0;
        int_eoi = 1'b0;
        check("l3_pend_kept", 16'(pending), 16'h08);
        check("l3_isr", 16'(in_service), 16'h08);
        pulse_eoi();
        check("l3_isr_clr", 16'(in_service), 16'h00);
        serve("l3_again", 8'h08);

        // All eight at once, served in index order.
        irq_in = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(16'h0100 + 16'(i * 2));
        end
        tick();
        irq_in = 8'h00;
        for (int i = 0; i < 8; i++) begin
            serve($sformatf("all8_l%0d", i), 8'(1 << i));
        end
        check("all8_pend", 16'(pending), 16'h00);

        // Asynchronous reset while a request is outstanding.
        irq_in = 8'h0C;
        tick();
        irq_in = 8'h00;
        tick();
        check("mid_req", 16'(int_req), 16'd1);
        check("mid_pend", 16'(pending), 16'h0C);
        #2;
        reset = 1'b0;
        #1;
        check("async_ie", 16'(ie), 16'h00);
        check("async_pend", 16'(pending), 16'h00);
        check("async_isr", 16'(in_service), 16'h00);
        check("async_req", 16'(int_req), 16'd0);
        check("async_vec", int_vector, 16'h0100);
        tick();
        reset = 1'b1;
        tick();

        check("sb_empty", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
